mux_alu_pipe: RTL and testbench

MUX_ALU_PIPE -- requirements
Module: mux_alu_pipe

---
 rtl/mux_alu_pipe.sv | 151 +++++++++++++++
 tb/tb_mux_alu_pipe.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_alu_pipe.sv
// Two-stage valid/ready ALU: S1 captures the request, S2 holds the registered result.
// Downstream backpressure is absorbed by the two stages before in_ready drops.
module mux_alu_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_flag,
    output logic             out_zero,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [2:0] OP_AND    = 3'd0;
    localparam logic [2:0] OP_OR     = 3'd1;
    localparam logic [2:0] OP_ADD    = 3'd2;
    localparam logic [2:0] OP_SUB    = 3'd3;
    localparam logic [2:0] OP_XOR    = 3'd4;
    localparam logic [2:0] OP_PASS_A = 3'd5;
    localparam logic [2:0] OP_ADDSUB = 3'd6;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Result in the low WIDTH bits, carry/borrow flag in the top bit.
    function automatic logic [WIDTH:0] alu_eval(
        input logic [2:0]       f_op,
        input logic [WIDTH-1:0] f_a,
        input logic [WIDTH-1:0] f_b
    );
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] res;
        logic             flag;
        sum  = {1'b0, f_a} + {1'b0, f_b};
        res  = '0;
        flag = 1'b0;
        case (f_op)
            OP_AND:    res = f_a & f_b;
            OP_OR:     res = f_a | f_b;
            OP_ADD: begin
                res  = sum[WIDTH-1:0];
                flag = sum[WIDTH];
            end
            OP_SUB: begin
                res  = f_a - f_b;
                flag = (f_a < f_b);
            end
            OP_XOR:    res = f_a ^ f_b;
            OP_PASS_A: res = f_a;
            OP_ADDSUB: res = sum[WIDTH-1:0] + (f_a - f_b);
            default:   res = f_a | f_b;
        endcase
        return {flag, res};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_ONE;
    endfunction

    logic             vld_p1_q, vld_p1_d;
    logic [2:0]       op_p1_q, op_p1_d;
    logic [WIDTH-1:0] a_p1_q, a_p1_d;
    logic [WIDTH-1:0] b_p1_q, b_p1_d;
    logic             vld_p2_q, vld_p2_d;
    logic [WIDTH-1:0] data_p2_q, data_p2_d;
    logic             flag_p2_q, flag_p2_d;
    logic             zero_p2_q, zero_p2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             s2_free, s1_adv, in_rdy, accept, xfer;
    logic [WIDTH:0]   alu_res;

    always_comb begin
        s2_free   = !vld_p2_q || out_ready;
        s1_adv    = vld_p1_q && s2_free;
        in_rdy    = !vld_p1_q || s2_free;
        accept    = in_valid && in_rdy;
        xfer      = vld_p2_q && out_ready;
        alu_res   = alu_eval(op_p1_q, a_p1_q, b_p1_q);

        vld_p1_d  = vld_p1_q;
        op_p1_d   = op_p1_q;
        a_p1_d    = a_p1_q;
        b_p1_d    = b_p1_q;
        vld_p2_d  = vld_p2_q;
        data_p2_d = data_p2_q;
        flag_p2_d = flag_p2_q;
        zero_p2_d = zero_p2_q;
        cnt_d     = cnt_q;

        if (accept) begin
            vld_p1_d = 1'b1;
            op_p1_d  = op;
            a_p1_d   = a;
            b_p1_d   = b;
        end else if (s1_adv) begin
            vld_p1_d = 1'b0;
        end

        if (s1_adv) begin
            vld_p2_d  = 1'b1;
            data_p2_d = alu_res[WIDTH-1:0];
            flag_p2_d = alu_res[WIDTH];
            zero_p2_d = (alu_res[WIDTH-1:0] == '0);
        end else if (xfer) begin
            vld_p2_d  = 1'b0;
        end

        if (xfer) cnt_d = sat_inc(cnt_q);
    end

    // Stage boundary S1: operand capture (data needs no reset, gated by vld_p1_q)
    always_ff @(posedge clk) begin
        op_p1_q <= op_p1_d;
        a_p1_q  <= a_p1_d;
        b_p1_q  <= b_p1_d;
    end

    // Stage boundary S2: registered result plus pipeline control
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            data_p2_q <= '0;
            flag_p2_q <= 1'b0;
            zero_p2_q <= 1'b1;
            cnt_q     <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            data_p2_q <= data_p2_d;
            flag_p2_q <= flag_p2_d;
            zero_p2_q <= zero_p2_d;
            cnt_q     <= cnt_d;
        end
    end

    assign in_ready  = in_rdy && !rst;
    assign out_valid = vld_p2_q && !rst;
    assign out_data  = data_p2_q;
    assign out_flag  = flag_p2_q;
    assign out_zero  = zero_p2_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_mux_alu_pipe.sv
// Directed bench for mux_alu_pipe: a WIDTH=8 instance plus a CNT_W=4 instance
// sharing the same stimulus to exercise counter saturation.
module tb_mux_alu_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [2:0] op;
    logic [7:0] a, b;
    logic       out_ready;

    logic       in_ready, out_valid, out_flag, out_zero;
    logic [7:0] out_data;
    logic [15:0] op_count;

    logic       in_ready2, out_valid2, out_flag2, out_zero2;
    logic [7:0] out_data2;
    logic [3:0] op_count2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mux_alu_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_flag(out_flag), .out_zero(out_zero),
        .op_count(op_count)
    );

    mux_alu_pipe #(.WIDTH(8), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .op(op), .a(a), .b(b), .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_flag(out_flag2), .out_zero(out_zero2),
        .op_count(op_count2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        in_valid = 1'b1;
        op = o;
        a  = x;
        b  = y;
        step();
        in_valid = 1'b0;
    endtask

    logic [7:0] stream_exp [8];
    int stale_seen;

    initial begin
        stream_exp = '{8'h0A, 8'hAF, 8'hB9, 8'h9B, 8'hA5, 8'hAA, 8'h54, 8'hAF};
        rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;

        // Reset state
        step(); step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_flag", out_flag, 0);
        chk("rst_out_zero", out_zero, 1);
        chk("rst_op_count", op_count, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // ADD with carry
        issue(3'd2, 8'hF0, 8'h20);
        chk("add_no_early_valid", out_valid, 0);
        step();
        chk("add_valid", out_valid, 1);
        chk("add_data", out_data, 8'h10);
        chk("add_flag", out_flag, 1);
        chk("add_zero", out_zero, 0);
        step();
        chk("add_count", op_count, 1);
        chk("add_drained", out_valid, 0);

        // SUB with borrow, then SUB to zero
        issue(3'd3, 8'h05, 8'h07);
        step();
        chk("sub_borrow_data", out_data, 8'hFE);
        chk("sub_borrow_flag", out_flag, 1);
        chk("sub_borrow_zero", out_zero, 0);
        issue(3'd3, 8'h07, 8'h07);
        step();
        chk("sub_zero_data", out_data, 8'h00);
        chk("sub_zero_flag", out_flag, 0);
        chk("sub_zero_zero", out_zero, 1);
        step();
        chk("sub_count", op_count, 3);

        // Backpressure: two buffered, third stalled
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd0; a = 8'hAA; b = 8'h0F;
        #1;
        chk("bp_ready1", in_ready, 1);
        step();
        op = 3'd1;
        #1;
        chk("bp_ready2", in_ready, 1);
        step();
        op = 3'd2;
        #1;
        chk("bp_ready3", in_ready, 0);
        chk("bp_hold_data", out_data, 8'h0A);
        step();
        chk("bp_still_stalled", in_ready, 0);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_data2", out_data, 8'h0A);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("bp_res2", out_data, 8'hAF);
        step();
        chk("bp_res3", out_data, 8'hB9);
        chk("bp_res3_flag", out_flag, 0);
        step();
        chk("bp_drained", out_valid, 0);
        chk("bp_count", op_count, 6);

        // Full-rate stream over all op codes
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; op = 3'(i); a = 8'hAA; b = 8'h0F;
            step();
            if (i >= 1) begin
                chk($sformatf("stream_vld%0d", i - 1), out_valid, 1);
                chk($sformatf("stream_data%0d", i - 1), out_data, stream_exp[i-1]);
                chk($sformatf("stream_flag%0d", i - 1), out_flag, 0);
                chk($sformatf("stream_rdy%0d", i), in_ready, 1);
            end
        end
        in_valid = 1'b0;
        step();
        chk("stream_data7", out_data, stream_exp[7]);
        chk("stream_flag7", out_flag, 0);
        step();
        chk("stream_drained", out_valid, 0);
        chk("stream_count", op_count, 14);

        // Reset with two results buffered and a request offered during reset
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd4; a = 8'h11; b = 8'h22;
        step();
        op = 3'd5; a = 8'h44;
        step();
        chk("prerst_valid", out_valid, 1);
        chk("prerst_data", out_data, 8'h33);
        rst = 1'b1; op = 3'd5; a = 8'h77;
        #1;
        chk("during_rst_valid", out_valid, 0);
        chk("during_rst_ready", in_ready, 0);
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_count", op_count, 0);
        chk("midrst_ready", in_ready, 1);
        chk("midrst_zero", out_zero, 1);
        stale_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid) stale_seen++;
        end
        chk("midrst_no_stale", stale_seen, 0);

        // Counter saturation on the CNT_W=4 instance
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; op = 3'd5; a = 8'(i); b = 8'h00;
            step();
        end
        in_valid = 1'b0;
        step(); step(); step();
        chk("sat_count4", op_count2, 4'hF);
        chk("sat_count16", op_count, 20);
        issue(3'd5, 8'h00, 8'h00);
        step();
        chk("pass_zero_data", out_data, 8'h00);
        chk("pass_zero_zero", out_zero, 1);
        issue(3'd7, 8'hA0, 8'h05);
        step();
        chk("op7_data", out_data, 8'hA5);
        chk("op7_flag", out_flag, 0);
        step();
        chk("sat_hold4", op_count2, 4'hF);
        chk("sat_more16", op_count, 22);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
